regwrite_trace_buffer: RTL and testbench
========================================

Name: regwrite_trace_buffer

Overview:
Synthesisable debug block that snoops the CPU register-file write-back port. It records selected register writes into a timestamped trace FIFO, which a debug host or testbench drains through a valid/ready port. Register count, data width, depth, timestamp width and overflow mode are all parametrised. It sits beside the register file and feeds the debug/trace path.

Parameters:
XLEN, 32, data width of one register write
REG_AW, 5, register address width (2**REG_AW registers)
DEPTH, 16, trace entries; power of two, >= 2
TS_W, 16, free-running timestamp width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset (0 = reset)
wb_en  in  1  register-file write strobe
wb_addr  in  REG_AW  write destination register
wb_data  in  XLEN  write data
capture_en  in  1  global capture enable
watch_mask  in  2**REG_AW  bit i=1 -> record writes to register i
ring_mode  in  1  0 = stop-when-full, 1 = overwrite oldest
clear  in  1  synchronous flush of trace state
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head entry
rd_ts  out  TS_W  head timestamp
rd_addr  out  REG_AW  head register address
rd_data  out  XLEN  head write data
count  out  clog2(DEPTH)+1  entries held
overflow  out  1  sticky: an entry was dropped or overwritten
drop_cnt  out  8  number of lost entries, saturates at 255

Behaviour:
- Reset (rst=0, async): pointers=0, count=0, rd_valid=0, overflow=0, drop_cnt=0, timestamp=0; rd_ts/rd_addr/rd_data=0.
- Timestamp: increments every clk after reset and wraps modulo 2**TS_W. It is not affected by clear.
- push = capture_en & wb_en & watch_mask[wb_addr] & (wb_addr!=0). Writes to x0 are never recorded.
- Entry = {timestamp sampled in the push cycle, wb_addr, wb_data}.
- Read port is first-word-fall-through. rd_valid = (count!=0).
- pop = rd_valid & rd_ready. rd_* must stay stable while rd_valid=1 and rd_ready=0.
- Latency: a push into an empty buffer gives rd_valid=1 on the next clk.
- Full with ring_mode=0:
  - push without pop: entry dropped, overflow<=1, drop_cnt+1 (saturating).
  - push with pop: both accepted, count unchanged, no loss.
- Full with ring_mode=1:
  - push without pop: oldest entry discarded (read pointer advances), new entry stored, count stays DEPTH, overflow<=1, drop_cnt+1.
  - push with pop: normal push+pop, no loss.
- Empty with pop requested: impossible, because rd_valid=0.
- clear=1: next clk pointers=0, count=0, overflow=0, drop_cnt=0. Clear has priority over a same-cycle push and pop; both are ignored.
- ring_mode and watch_mask are sampled every cycle. A change affects only subsequent pushes, and stored entries are untouched.
- Pointers are clog2(DEPTH) bits and wrap naturally. count disambiguates full from empty.
- Reset asserted mid-operation discards all contents immediately.

Optional Feature:
Macro TRACE_CHANGE_ONLY_EN.
- Defined:
  - A shadow copy of every register's last recorded value is held, reset to 0.
  - A push whose wb_data equals the shadow value for wb_addr is suppressed: no entry, no drop count.
  - The shadow is updated only when an entry is actually stored.
  - clear resets the shadow to 0.
  - In ring_mode=0, a dropped entry does not update the shadow.
- Undefined: every qualifying write is recorded and no shadow storage exists.

Test Plan:
- Reset release, capture_en=1, mask=0x1C; writes x2=5 at ts=3, x3=7 at ts=4 -> rd_valid next clk; pop order is {3,2,5} then {4,3,7}; count returns to 0.
- Write to x1 (mask bit 0) and x0 with mask all ones -> nothing recorded, count=0, rd_valid=0.
- ring_mode=0, DEPTH=16, rd_ready=0, 20 writes of data 1..20 -> count=16, overflow=1, drop_cnt=4; drained data is 1..16.
- ring_mode=1, same stimulus -> count=16, drop_cnt=4; drained data is 5..20.
- Full buffer, ring_mode=0, push and pop in the same cycle -> count stays 16, drop_cnt unchanged; then clear with a simultaneous push -> count=0, overflow=0, drop_cnt=0.
- TRACE_CHANGE_ONLY_EN defined: x4 written 9, 9, 3 -> two entries (9, 3). Undefined: three entries.

Source files
------------

// File: rtl/regwrite_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// regwrite_trace_buffer_if
//
// Bundles the register-file write-back snoop signals and the trace read port
// of regwrite_trace_buffer.
//
//   wb_en / wb_addr / wb_data           register-file write-back strobe
//   rd_valid / rd_ready                 trace drain handshake
//   rd_ts / rd_addr / rd_data           head entry of the trace FIFO
//
// Modports:
//   master : the side that drives write-backs and drains the trace
//   slave  : the trace buffer itself
//
// The interface parameters must match the trace buffer's XLEN/REG_AW/TS_W.
// ---------------------------------------------------------------------------
interface regwrite_trace_buffer_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int TS_W   = 16
);
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [TS_W-1:0]   rd_ts;
    logic [REG_AW-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;

    modport master (
        output wb_en, wb_addr, wb_data, rd_ready,
        input  rd_valid, rd_ts, rd_addr, rd_data
    );

    modport slave (
        input  wb_en, wb_addr, wb_data, rd_ready,
        output rd_valid, rd_ts, rd_addr, rd_data
    );
endinterface

// File: rtl/regwrite_trace_buffer.sv
// ---------------------------------------------------------------------------
// regwrite_trace_buffer
//
// Snoops the register-file write-back port and records selected writes as
// {timestamp, register, data} entries in a first-word-fall-through FIFO that
// a debug host drains over a valid/ready port.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active low (0 = reset)
//   bus         regwrite_trace_buffer_if.slave: wb_* snoop inputs and the
//               rd_* drain port (rd_valid, rd_ready, rd_ts, rd_addr, rd_data)
//   capture_en  global capture enable
//   watch_mask  bit i set -> writes to register i are recorded (x0 never is)
//   ring_mode   0 = drop new entries when full, 1 = overwrite the oldest
//   clear       synchronous flush of pointers, count and loss statistics
//   count       number of entries held (0..DEPTH)
//   overflow    sticky: an entry was dropped or overwritten since last clear
//   drop_cnt    number of lost entries, saturating at 255
//
// Optional build macro TRACE_CHANGE_ONLY_EN: keeps a shadow of the last
// recorded value of every register and suppresses writes that do not change
// it. Without the macro every qualifying write is recorded.
// ---------------------------------------------------------------------------
module regwrite_trace_buffer #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    regwrite_trace_buffer_if.slave   bus,
    input  logic                     capture_en,
    input  logic [2**REG_AW-1:0]     watch_mask,
    input  logic                     ring_mode,
    input  logic                     clear,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 2**REG_AW;
    localparam int EW   = TS_W + REG_AW + XLEN;

    logic [TS_W-1:0] ts_reg;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg,  count_next;
    logic            overflow_reg, overflow_next;
    logic [7:0]      drop_cnt_reg, drop_cnt_next;

    logic [EW-1:0]   mem [DEPTH];
    logic [EW-1:0]   head;

    logic qualify, push, pop, full, empty;
    logic store, lose, evict, wr_en;

    // A write qualifies when capture is on, the register is watched and it
    // is not the hard-wired zero register.
    assign qualify = capture_en & bus.wb_en & watch_mask[bus.wb_addr]
                   & (bus.wb_addr != '0);

`ifdef TRACE_CHANGE_ONLY_EN
    logic [XLEN-1:0] shadow [NREG];

    assign push = qualify & (bus.wb_data != shadow[bus.wb_addr]);
`else
    assign push = qualify;
`endif

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign pop   = ~empty & bus.rd_ready;

    // When full, a same-cycle pop frees the slot the push needs, so only a
    // push without pop loses anything. In ring mode the loss is the oldest
    // entry (read pointer skips it) rather than the new one.
    assign store = push & (~full | pop | ring_mode);
    assign lose  = push & full & ~pop;
    assign evict = lose & ring_mode;
    assign wr_en = store & ~clear;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (clear) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
            drop_cnt_next = '0;
        end else begin
            wr_ptr_next = wr_ptr_reg + PW'(store);
            rd_ptr_next = rd_ptr_reg + PW'(pop | evict);
            // An evicting store leaves count at DEPTH, hence the ~full term.
            if (store & ~pop & ~full)
                count_next = count_reg + CW'(1);
            else if (pop & ~store)
                count_next = count_reg - CW'(1);
            if (lose) begin
                overflow_next = 1'b1;
                if (drop_cnt_reg != 8'hFF)
                    drop_cnt_next = drop_cnt_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_reg       <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            // Free-running; clear deliberately leaves it alone.
            ts_reg       <= ts_reg + TS_W'(1);
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Storage carries no reset: stale words are never visible because the
    // read outputs are gated by rd_valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr_reg] <= {ts_reg, bus.wb_addr, bus.wb_data};
    end

`ifdef TRACE_CHANGE_ONLY_EN
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_shadow
            logic [XLEN-1:0] val_reg;
            // Follows only entries that were really stored, so a write that
            // was dropped in stop-when-full mode is retried next time.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    val_reg <= '0;
                else if (clear)
                    val_reg <= '0;
                else if (wr_en && bus.wb_addr == REG_AW'(gi))
                    val_reg <= bus.wb_data;
            end
            assign shadow[gi] = val_reg;
        end
    endgenerate
`endif

    // First-word-fall-through head; outputs read as zero while empty.
    assign head         = mem[rd_ptr_reg];
    assign bus.rd_valid = ~empty;
    assign bus.rd_data  = empty ? '0 : head[XLEN-1:0];
    assign bus.rd_addr  = empty ? '0 : head[XLEN +: REG_AW];
    assign bus.rd_ts    = empty ? '0 : head[XLEN+REG_AW +: TS_W];

    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign drop_cnt = drop_cnt_reg;
endmodule

// File: tb/tb_regwrite_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_regwrite_trace_buffer
//
// Self-checking bench for regwrite_trace_buffer. A queue-based reference
// model tracks the expected trace contents and statistics every cycle; a
// vector table and several hand sequences add fixed expectations, followed
// by randomized traffic. Honours TRACE_CHANGE_ONLY_EN like the design.
// ---------------------------------------------------------------------------
module tb_regwrite_trace_buffer;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 16;
    localparam int NREG   = 2**REG_AW;

    logic                    clk;
    logic                    rst;
    logic                    capture_en;
    logic [NREG-1:0]         watch_mask;
    logic                    ring_mode;
    logic                    clear;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;
    logic [7:0]              drop_cnt;

    regwrite_trace_buffer_if #(.XLEN(XLEN), .REG_AW(REG_AW), .TS_W(TS_W)) bus ();

    regwrite_trace_buffer #(
        .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .capture_en (capture_en),
        .watch_mask (watch_mask),
        .ring_mode  (ring_mode),
        .clear      (clear),
        .count      (count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } entry_t;

    entry_t          mq[$];
    logic            m_ovf;
    int              m_drop;
    logic [TS_W-1:0] m_ts;
`ifdef TRACE_CHANGE_ONLY_EN
    logic [XLEN-1:0] m_shadow [NREG];
`endif

    logic [XLEN-1:0] popped[$];
    logic [XLEN-1:0] exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        m_ts   = '0;
`ifdef TRACE_CHANGE_ONLY_EN
        for (int i = 0; i < NREG; i++) m_shadow[i] = '0;
`endif
    endtask

    // Applies the rules to the inputs present before the coming edge.
    task automatic model_step();
        entry_t e;
        logic   push;
        if (clear) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
`ifdef TRACE_CHANGE_ONLY_EN
            for (int i = 0; i < NREG; i++) m_shadow[i] = '0;
`endif
        end else begin
            if (bus.rd_valid && bus.rd_ready) popped.push_back(bus.rd_data);
            if (mq.size() != 0 && bus.rd_ready) void'(mq.pop_front());
            push = capture_en && bus.wb_en && watch_mask[bus.wb_addr] && (bus.wb_addr != 0);
`ifdef TRACE_CHANGE_ONLY_EN
            if (push && bus.wb_data == m_shadow[bus.wb_addr]) push = 1'b0;
`endif
            if (push) begin
                e.ts   = m_ts;
                e.addr = bus.wb_addr;
                e.data = bus.wb_data;
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
`ifdef TRACE_CHANGE_ONLY_EN
                    m_shadow[bus.wb_addr] = bus.wb_data;
`endif
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                    if (ring_mode) begin
                        void'(mq.pop_front());
                        mq.push_back(e);
`ifdef TRACE_CHANGE_ONLY_EN
                        m_shadow[bus.wb_addr] = bus.wb_data;
`endif
                    end
                end
            end
        end
        m_ts = m_ts + 1'b1;
    endtask

    task automatic compare_model();
        chk("model_count", count, mq.size());
        chk("model_valid", bus.rd_valid, mq.size() != 0);
        chk("model_overflow", overflow, m_ovf);
        chk("model_drop", drop_cnt, m_drop);
        if (mq.size() != 0) begin
            chk("model_rd_ts", bus.rd_ts, mq[0].ts);
            chk("model_rd_addr", bus.rd_addr, mq[0].addr);
            chk("model_rd_data", bus.rd_data, mq[0].data);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drv(input bit en, input int addr, input logic [XLEN-1:0] data, input bit ready);
        bus.wb_en    = en;
        bus.wb_addr  = REG_AW'(addr);
        bus.wb_data  = data;
        bus.rd_ready = ready;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drv(0, 0, 0, 0);
        step();
        clear = 1'b0;
    endtask

    task automatic fill(input int first, input int n, input int addr);
        for (int k = 0; k < n; k++) begin
            drv(1, addr, XLEN'(first + k), 0);
            step();
        end
        drv(0, 0, 0, 0);
    endtask

    // Drains n cycles with rd_ready high and compares popped data to exp_q.
    task automatic drain(input string tag, input int n);
        popped.delete();
        drv(0, 0, 0, 1);
        repeat (n) step();
        drv(0, 0, 0, 0);
        chk({tag, "_len"}, popped.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < popped.size()) chk({tag, "_data"}, popped[k], exp_q[k]);
        chk({tag, "_count_after"}, count, 0);
        $display("drain %s: %0d entries popped", tag, popped.size());
    endtask

    task automatic stats(input string tag, input int c, input int ov, input int dr);
        chk({tag, "_count"}, count, c);
        chk({tag, "_overflow"}, overflow, ov);
        chk({tag, "_drop"}, drop_cnt, dr);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int              en;
        int              addr;
        logic [XLEN-1:0] data;
        int              cap;
        logic [NREG-1:0] mask;
        int              ready;
        int              exp_count;
        int              exp_valid;
        int              exp_ts;
        int              exp_addr;
        logic [XLEN-1:0] exp_data;
    } vec_t;

    function automatic vec_t mk(input int en, input int addr, input logic [XLEN-1:0] data,
                                input int cap, input logic [NREG-1:0] mask, input int ready,
                                input int ec, input int ev, input int ets, input int ea,
                                input logic [XLEN-1:0] ed);
        vec_t v;
        v.en = en; v.addr = addr; v.data = data; v.cap = cap; v.mask = mask; v.ready = ready;
        v.exp_count = ec; v.exp_valid = ev; v.exp_ts = ets; v.exp_addr = ea; v.exp_data = ed;
        return v;
    endfunction

    vec_t vt[12];

    initial begin
        int n_change;

        vt[0]  = mk(0, 0, 0,  1, 32'h1C,       0, 0, 0, 0,  0, 0);
        vt[1]  = mk(0, 0, 0,  1, 32'h1C,       0, 0, 0, 0,  0, 0);
        vt[2]  = mk(0, 0, 0,  1, 32'h1C,       0, 0, 0, 0,  0, 0);
        vt[3]  = mk(1, 2, 5,  1, 32'h1C,       0, 1, 1, 3,  2, 5);
        vt[4]  = mk(1, 3, 7,  1, 32'h1C,       0, 2, 1, 3,  2, 5);
        vt[5]  = mk(0, 0, 0,  1, 32'h1C,       1, 1, 1, 4,  3, 7);
        vt[6]  = mk(0, 0, 0,  1, 32'h1C,       1, 0, 0, 0,  0, 0);
        vt[7]  = mk(1, 1, 11, 1, 32'h1C,       0, 0, 0, 0,  0, 0);
        vt[8]  = mk(1, 0, 12, 1, 32'hFFFFFFFF, 0, 0, 0, 0,  0, 0);
        vt[9]  = mk(1, 5, 1,  0, 32'hFFFFFFFF, 0, 0, 0, 0,  0, 0);
        vt[10] = mk(1, 5, 13, 1, 32'hFFFFFFFF, 0, 1, 1, 10, 5, 13);
        vt[11] = mk(0, 0, 0,  1, 32'hFFFFFFFF, 1, 0, 0, 0,  0, 0);

        rst        = 1'b0;
        capture_en = 1'b0;
        watch_mask = '0;
        ring_mode  = 1'b0;
        clear      = 1'b0;
        drv(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        stats("reset", 0, 0, 0);
        chk("reset_valid", bus.rd_valid, 0);
        chk("reset_rd_ts", bus.rd_ts, 0);
        chk("reset_rd_addr", bus.rd_addr, 0);
        chk("reset_rd_data", bus.rd_data, 0);
        rst = 1'b1;

        // Basic capture, ordering, latency and filtering.
        for (int i = 0; i < 12; i++) begin
            drv(vt[i].en != 0, vt[i].addr, vt[i].data, vt[i].ready != 0);
            capture_en = (vt[i].cap != 0);
            watch_mask = vt[i].mask;
            step();
            chk("vec_count", count, vt[i].exp_count);
            chk("vec_valid", bus.rd_valid, vt[i].exp_valid);
            if (vt[i].exp_valid != 0) begin
                chk("vec_ts", bus.rd_ts, vt[i].exp_ts);
                chk("vec_addr", bus.rd_addr, vt[i].exp_addr);
                chk("vec_data", bus.rd_data, vt[i].exp_data);
            end
            $display("vec %0d: en=%0d x%0d=%0d ready=%0d -> count=%0d valid=%0d",
                     i, vt[i].en, vt[i].addr, vt[i].data, vt[i].ready, count, bus.rd_valid);
        end

        capture_en = 1'b1;
        watch_mask = '1;

        // Stop-when-full: 20 writes into 16 slots keep the first 16.
        do_clear();
        ring_mode = 1'b0;
        fill(1, 20, 6);
        stats("stop_full", 16, 1, 4);
        exp_q.delete();
        for (int k = 1; k <= 16; k++) exp_q.push_back(XLEN'(k));
        drain("stop_drain", 16);

        // Ring mode: same stimulus keeps the newest 16.
        do_clear();
        stats("clear1", 0, 0, 0);
        ring_mode = 1'b1;
        fill(1, 20, 6);
        stats("ring_full", 16, 1, 4);
        exp_q.delete();
        for (int k = 5; k <= 20; k++) exp_q.push_back(XLEN'(k));
        drain("ring_drain", 16);

        // Full, stop mode: push+pop loses nothing; then clear beats push.
        do_clear();
        ring_mode = 1'b0;
        fill(1, 16, 6);
        stats("full16", 16, 0, 0);
        drv(1, 7, 50, 1);
        step();
        stats("full_pushpop", 16, 0, 0);
        drv(1, 7, 51, 0);
        step();
        stats("full_drop", 16, 1, 1);
        clear = 1'b1;
        drv(1, 8, 52, 1);
        step();
        clear = 1'b0;
        drv(0, 0, 0, 0);
        stats("clear_push", 0, 0, 0);
        chk("clear_push_valid", bus.rd_valid, 0);
        $display("full/clear sequence: count=%0d overflow=%0d drop=%0d", count, overflow, drop_cnt);

        // Change-only filter on x4: 9, 9, 3.
        do_clear();
        drv(1, 4, 9, 0); step();
        drv(1, 4, 9, 0); step();
        drv(1, 4, 3, 0); step();
        drv(0, 0, 0, 0);
        exp_q.delete();
`ifdef TRACE_CHANGE_ONLY_EN
        n_change = 2;
        exp_q.push_back(9); exp_q.push_back(3);
`else
        n_change = 3;
        exp_q.push_back(9); exp_q.push_back(9); exp_q.push_back(3);
`endif
        chk("change_count", count, n_change);
        drain("change_drain", n_change);

        // Drop counter saturation with a long stream into a full buffer.
        do_clear();
        ring_mode = 1'b1;
        fill(1, 16 + 270, 9);
        stats("saturate", 16, 1, 255);
        $display("saturation: drop_cnt=%0d", drop_cnt);

        // Randomized traffic with one asynchronous reset in the middle.
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                watch_mask = $urandom;
                ring_mode  = $urandom_range(0, 1);
            end
            capture_en = ($urandom_range(0, 7) != 0);
            clear      = ($urandom_range(0, 99) == 0);
            drv($urandom_range(0, 3) != 0, $urandom_range(0, NREG - 1),
                XLEN'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
            step();
            if (c == 1500) begin
                rst = 1'b0;
                #1;
                stats("async_reset", 0, 0, 0);
                chk("async_reset_valid", bus.rd_valid, 0);
                chk("async_reset_data", bus.rd_data, 0);
                model_reset();
                @(posedge clk);
                #1;
                rst = 1'b1;
                $display("mid-run reset applied at cycle %0d", c);
            end
        end
        clear = 1'b0;
        $display("random phase done: count=%0d overflow=%0d drop=%0d", count, overflow, drop_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
